// File: rtl/lu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lu_vector_sequencer
// Purpose  : Sweeps all 8 {sel,a,b} vectors through the OR/NOR logic unit and
//            packs the sampled outputs into a byte. Optional self-check is
//            built when LU_SEQ_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module lu_vector_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step_en,
    input  logic       lu_out,
    output logic       lu_a,
    output logic       lu_b,
    output logic       lu_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] results,
    output logic       pass,
    output logic [3:0] err_cnt
);

    localparam logic [3:0] c_hold_last = 4'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [2:0] r_idx;
    logic [3:0] r_hold;
    logic       r_lu_a;
    logic       r_lu_b;
    logic       r_lu_sel;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_results;

    logic       w_accept;
    logic       w_sample;
    logic       w_last;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_drive;
                end
            end
            c_st_drive: begin
                if (r_hold == c_hold_last) begin
                    w_sample = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_last       = 1'b1;
                        w_state_next = c_st_done;
                    end
                end
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else if (step_en) begin
            r_state <= w_state_next;
        end
    end

    // step_en low freezes every register, including a pending done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= 3'd0;
            r_hold    <= 4'd0;
            r_lu_a    <= 1'b0;
            r_lu_b    <= 1'b0;
            r_lu_sel  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_results <= 8'd0;
        end else if (step_en) begin
            if (w_accept) begin
                r_idx                      <= 3'd0;
                r_hold                     <= 4'd0;
                r_busy                     <= 1'b1;
                r_results                  <= 8'd0;
                {r_lu_sel, r_lu_a, r_lu_b} <= 3'd0;
            end else if (r_state == c_st_drive) begin
                if (w_sample) begin
                    r_hold           <= 4'd0;
                    r_results[r_idx] <= lu_out;
                    if (w_last) begin
                        r_busy                     <= 1'b0;
                        r_done                     <= 1'b1;
                        {r_lu_sel, r_lu_a, r_lu_b} <= 3'd0;
                    end else begin
                        r_idx                      <= r_idx + 3'd1;
                        {r_lu_sel, r_lu_a, r_lu_b} <= r_idx + 3'd1;
                    end
                end else begin
                    r_hold <= r_hold + 4'd1;
                end
            end else if (r_state == c_st_done) begin
                r_done <= 1'b0;
            end
        end
    end

`ifdef LU_SEQ_CHECK_EN
    logic       w_expected;
    logic [3:0] w_err_next;
    logic [3:0] r_err_cnt;
    logic       r_pass;

    always_comb begin
        w_expected = r_lu_sel ? (r_lu_a | r_lu_b) : ~(r_lu_a | r_lu_b);
        w_err_next = r_err_cnt;
        if (w_sample && (w_expected != lu_out) && (r_err_cnt != 4'd8)) begin
            w_err_next = r_err_cnt + 4'd1;
        end
    end

    // pass uses the post-update count so the final vector's mismatch counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 4'd0;
            r_pass    <= 1'b0;
        end else if (step_en) begin
            if (w_accept) begin
                r_err_cnt <= 4'd0;
                r_pass    <= 1'b0;
            end else begin
                r_err_cnt <= w_err_next;
                if (w_last) begin
                    r_pass <= (w_err_next == 4'd0);
                end
            end
        end
    end

    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
`else
    assign pass    = 1'b0;
    assign err_cnt = 4'd0;
`endif

    assign lu_a    = r_lu_a;
    assign lu_b    = r_lu_b;
    assign lu_sel  = r_lu_sel;
    assign busy    = r_busy;
    assign done    = r_done;
    assign results = r_results;

endmodule
`default_nettype wire

// File: tb/tb_lu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_vector_sequencer
// Purpose  : Directed self-checking bench; one DUT with HOLD_CYCLES=1 and one
//            with HOLD_CYCLES=3, each fed by a model of the OR/NOR unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_vector_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start1, step1, start3, step3;
    logic       a1, b1, sel1, busy1, done1, pass1, lu_out1;
    logic       a3, b3, sel3, busy3, done3, pass3, lu_out3;
    logic [7:0] res1, res3;
    logic [3:0] err1, err3;
    int         fault_mode;   // 0 golden, 1 stuck-at-0, 2 stuck-at-1
    int         n_checks;
    int         n_pass;

    function automatic logic lu_model(input logic s, input logic a, input logic b, input int fm);
        if (fm == 1) return 1'b0;
        if (fm == 2) return 1'b1;
        return s ? (a | b) : ~(a | b);
    endfunction

    assign lu_out1 = lu_model(sel1, a1, b1, fault_mode);
    assign lu_out3 = lu_model(sel3, a3, b3, fault_mode);

    lu_vector_sequencer #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .step_en(step1), .lu_out(lu_out1),
        .lu_a(a1), .lu_b(b1), .lu_sel(sel1), .busy(busy1), .done(done1),
        .results(res1), .pass(pass1), .err_cnt(err1)
    );

    lu_vector_sequencer #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .step_en(step3), .lu_out(lu_out3),
        .lu_a(a3), .lu_b(b3), .lu_sel(sel3), .busy(busy3), .done(done3),
        .results(res3), .pass(pass3), .err_cnt(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full H=1 sweep on u_dut1 with a start pulse at edge 0.
    task automatic sweep1(input string tag, input logic [7:0] exp_res,
                          input logic [3:0] exp_err, input logic exp_pass);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_val({tag, "_accept_busy"}, busy1, 1);
        check_val({tag, "_accept_res"}, res1, 0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e < 8) begin
                check_val($sformatf("%s_vec%0d", tag, e), {sel1, a1, b1}, e);
                check_val($sformatf("%s_nodone%0d", tag, e), done1, 0);
            end else begin
                check_val({tag, "_done"}, done1, 1);
                check_val({tag, "_busy_low"}, busy1, 0);
                check_val({tag, "_results"}, res1, exp_res);
`ifdef LU_SEQ_CHECK_EN
                check_val({tag, "_err_cnt"}, err1, exp_err);
                check_val({tag, "_pass"}, pass1, exp_pass);
`endif
            end
        end
        tick();
        check_val({tag, "_done_pulse_end"}, done1, 0);
        check_val({tag, "_results_held"}, res1, exp_res);
    endtask

    initial begin
        logic seen_done;
        n_checks   = 0;
        n_pass     = 0;
        fault_mode = 0;
        rst_n      = 1'b0;
        start1     = 1'b0;
        start3     = 1'b0;
        step1      = 1'b1;
        step3      = 1'b1;
        tick();
        tick();
        check_val("rst_outputs1", {a1, b1, sel1, busy1, done1, pass1}, 0);
        check_val("rst_results1", res1, 0);
        check_val("rst_err1", err1, 0);
        rst_n = 1'b1;
        tick();

        // Golden unit, H=1.
        sweep1("gold", 8'hE1, 4'd0, 1'b1);

        // Freeze for 4 cycles while idx = 2; done shifts by 4 edges.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        check_val("frz_vec2", {sel1, a1, b1}, 2);
        step1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("frz_hold%0d", i), {sel1, a1, b1, done1}, 4'b0100);
        end
        step1 = 1'b1;
        for (int e = 3; e <= 8; e++) begin
            tick();
            if (e < 8) check_val($sformatf("frz_vec%0d", e), {sel1, a1, b1}, e);
        end
        check_val("frz_done", done1, 1);
        check_val("frz_results", res1, 8'hE1);
        step1 = 1'b0;
        tick();
        check_val("frz_done_held", done1, 1);
        step1 = 1'b1;
        tick();
        check_val("frz_done_clear", done1, 0);

        // H=3: start re-pulsed at edge 5 and during DONE must be ignored.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            start3 = (e == 5);
            tick();
            if (e < 24) begin
                check_val($sformatf("h3_vec_e%0d", e), {sel3, a3, b3, done3}, {3'(e / 3), 1'b0});
            end
        end
        start3 = 1'b0;
        check_val("h3_done", done3, 1);
        check_val("h3_results", res3, 8'hE1);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check_val("h3_start_in_done_ignored", {busy3, done3}, 0);
        tick();
        check_val("h3_idle", {busy3, done3, sel3, a3, b3}, 0);

        // Reset mid-sweep: outputs clear, no done follows.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check_val("midrst_outputs", {a3, b3, sel3, busy3, done3, pass3}, 0);
        check_val("midrst_results3", res3, 0);
        check_val("midrst_results1", res1, 0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done3) seen_done = 1'b1;
        end
        check_val("midrst_no_done", seen_done, 0);

        // Faulty unit.
        fault_mode = 1;
        sweep1("stuck0", 8'h00, 4'd4, 1'b0);
        fault_mode = 2;
        sweep1("stuck1", 8'hFF, 4'd4, 1'b0);
        fault_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
